// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: owns pc and the instruction register,
// steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and halts on traps.
module multicycle_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [2:0]  imm_sel,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        illegal
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISCMEM  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [31:0] pc_nx;
    logic [31:0] inst_nx;
    logic        halted_nx;
    logic        illegal_nx;

    logic [6:0]  opcode;
    logic        is_lui;
    logic        is_auipc;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_opimm;
    logic        is_op;
    logic        is_miscmem;
    logic        is_system;
    logic        is_legal;
    logic        is_jump;

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_target;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        branch_misaligned;
    logic        jump_misaligned;

    assign opcode     = inst[6:0];
    assign is_lui     = (opcode == OP_LUI);
    assign is_auipc   = (opcode == OP_AUIPC);
    assign is_jal     = (opcode == OP_JAL);
    assign is_jalr    = (opcode == OP_JALR);
    assign is_branch  = (opcode == OP_BRANCH);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_opimm   = (opcode == OP_OPIMM);
    assign is_op      = (opcode == OP_OP);
    assign is_miscmem = (opcode == OP_MISCMEM);
    assign is_system  = (opcode == OP_SYSTEM);
    assign is_jump    = is_jal | is_jalr;
    assign is_legal   = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load
                      | is_store | is_opimm | is_op | is_miscmem | is_system;

    // All targets are computed modulo 2^32; JALR drops bit 0 before the alignment check.
    assign pc_plus4          = pc + 32'd4;
    assign pc_plus_imm       = pc + imm;
    assign jalr_target       = alu_result & ~32'h1;
    assign branch_target     = branch_taken ? pc_plus_imm : pc_plus4;
    assign jump_target       = is_jal ? pc_plus_imm : jalr_target;
    assign branch_misaligned = (branch_target[1:0] != 2'b00);
    assign jump_misaligned   = is_jump && (jump_target[1:0] != 2'b00);

    always_comb begin
        imm_sel = IMM_I;
        case (opcode)
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            OP_JAL:           imm_sel = IMM_J;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_STORE:         imm_sel = IMM_S;
            default:          imm_sel = IMM_I;
        endcase
    end

    always_comb begin
        wb_sel = WB_ALU;
        if (is_load) begin
            wb_sel = WB_MEM;
        end else if (is_jump) begin
            wb_sel = WB_PC4;
        end else if (is_lui) begin
            wb_sel = WB_IMM;
        end
    end

    // Memory port and writeback strobes are pure decodes of the current state.
    assign mem_valid = (state == S_FETCH) || (state == S_MEMORY);
    assign mem_we    = (state == S_MEMORY) && is_store;
    assign reg_we    = (state == S_WRITEBACK) && !jump_misaligned;

    always_comb begin
        mem_addr = 32'h0;
        if (state == S_FETCH) begin
            mem_addr = pc;
        end else if (state == S_MEMORY) begin
            mem_addr = alu_result;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        inst_nx    = inst;
        halted_nx  = halted;
        illegal_nx = illegal;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    inst_nx  = mem_rdata;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    state_nx   = S_HALT;
                    halted_nx  = 1'b1;
                    illegal_nx = 1'b1;
                end else if (is_system) begin
                    state_nx  = S_HALT;
                    halted_nx = 1'b1;
                end else begin
                    state_nx = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_nx = S_MEMORY;
                end else if (is_branch) begin
                    if (branch_misaligned) begin
                        state_nx   = S_HALT;
                        halted_nx  = 1'b1;
                        illegal_nx = 1'b1;
                    end else begin
                        pc_nx    = branch_target;
                        state_nx = S_FETCH;
                    end
                end else if (is_miscmem) begin
                    pc_nx    = pc_plus4;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (is_store) begin
                        pc_nx    = pc_plus4;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                // A misaligned jump traps here with reg_we suppressed, leaving pc on the jump.
                if (jump_misaligned) begin
                    state_nx   = S_HALT;
                    halted_nx  = 1'b1;
                    illegal_nx = 1'b1;
                end else begin
                    pc_nx    = is_jump ? jump_target : pc_plus4;
                    state_nx = S_FETCH;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx  = S_HALT;
                halted_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            inst    <= NOP_INST;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            inst    <= inst_nx;
            halted  <= halted_nx;
            illegal <= illegal_nx;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner-case sequences,
// and randomized instructions checked against a per-instruction outcome model.
module tb_multicycle_control;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [2:0]  imm_sel;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] pc;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        illegal;

    multicycle_control #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .inst         (inst),
        .imm_sel      (imm_sel),
        .imm          (imm),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .pc           (pc),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reset_before;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        taken;
        int          fw;
        int          mw;
        logic [31:0] exp_pc;
        logic        exp_reg_we;
        logic [1:0]  exp_wb_sel;
        logic        exp_halt;
        logic        exp_illegal;
        int          exp_cycles;
        int          mem_op;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tb_pc;
    logic [31:0] tb_prev_inst;
    vec_t        vecs[$];

    function automatic vec_t mk_vec(input logic rb, input logic [31:0] instr, input logic [31:0] imm_v,
                                    input logic [31:0] alu_v, input logic taken_v, input int fw, input int mw,
                                    input logic [31:0] exp_pc, input logic rwe, input logic [1:0] wbs,
                                    input logic hlt, input logic ill, input int cyc, input int mop);
        vec_t v;
        v.reset_before = rb;   v.instr = instr;     v.imm = imm_v;       v.alu = alu_v;
        v.taken = taken_v;     v.fw = fw;           v.mw = mw;           v.exp_pc = exp_pc;
        v.exp_reg_we = rwe;    v.exp_wb_sel = wbs;  v.exp_halt = hlt;    v.exp_illegal = ill;
        v.exp_cycles = cyc;    v.mem_op = mop;
        return v;
    endfunction

    // Outcome of one instruction from the ISA-level rules: CPI, writeback, next pc or trap.
    function automatic vec_t ref_model(input logic [31:0] instr, input logic [31:0] imm_v,
                                       input logic [31:0] alu_v, input logic taken_v, input logic [31:0] cur_pc);
        vec_t v;
        logic [31:0] tgt;
        logic [6:0]  op;
        op = instr[6:0];
        v = mk_vec(1'b0, instr, imm_v, alu_v, taken_v, 0, 0, cur_pc + 32'd4, 1'b0, 2'd0, 1'b0, 1'b0, 4, 0);
        case (op)
            7'b0110111: begin v.exp_reg_we = 1'b1; v.exp_wb_sel = 2'd3; end
            7'b0010111, 7'b0010011, 7'b0110011: v.exp_reg_we = 1'b1;
            7'b1101111, 7'b1100111: begin
                tgt = (op == 7'b1101111) ? cur_pc + imm_v : {alu_v[31:1], 1'b0};
                if (tgt % 4 != 0) begin
                    v.exp_pc = cur_pc; v.exp_halt = 1'b1; v.exp_illegal = 1'b1;
                end else begin
                    v.exp_pc = tgt; v.exp_reg_we = 1'b1; v.exp_wb_sel = 2'd2;
                end
            end
            7'b1100011: begin
                v.exp_cycles = 3;
                tgt = taken_v ? cur_pc + imm_v : cur_pc + 32'd4;
                if (tgt % 4 != 0) begin
                    v.exp_pc = cur_pc; v.exp_halt = 1'b1; v.exp_illegal = 1'b1;
                end else begin
                    v.exp_pc = tgt;
                end
            end
            7'b0000011: begin v.exp_cycles = 5; v.mem_op = 1; v.exp_reg_we = 1'b1; v.exp_wb_sel = 2'd1; end
            7'b0100011: v.mem_op = 2;
            7'b0001111: v.exp_cycles = 3;
            7'b1110011: begin v.exp_cycles = 2; v.exp_pc = cur_pc; v.exp_halt = 1'b1; end
            default: begin
                v.exp_cycles = 2; v.exp_pc = cur_pc; v.exp_halt = 1'b1; v.exp_illegal = 1'b1;
            end
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tb_pc = RESET_PC;
        tb_prev_inst = 32'h0000_0013;
        checkOutput("reset_pc", pc, RESET_PC);
        checkOutput("reset_inst", inst, 32'h0000_0013);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("reset_mem_valid", {31'd0, mem_valid}, 32'd1);
        checkOutput("reset_mem_addr", mem_addr, RESET_PC);
        checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset_reg_we", {31'd0, reg_we}, 32'd0);
    endtask

    // Runs one instruction from its FETCH cycle, acting as memory and datapath, then checks the outcome.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] start_pc;
        logic [31:0] rnd;
        logic [1:0]  wb_seen;
        int total, valid_cycles, reg_we_cycles, bad_fetch, bad_data, bad_inst, pc_moved;
        int access_idx, wait_cnt, target, exp_valid;
        start_pc = tb_pc;
        valid_cycles = 0; reg_we_cycles = 0; bad_fetch = 0; bad_data = 0; bad_inst = 0;
        pc_moved = 0; access_idx = 0; wait_cnt = 0; wb_seen = 2'd0;
        imm = v.imm;
        alu_result = v.alu;
        branch_taken = v.taken;
        total = v.exp_cycles + v.fw + ((v.mem_op != 0) ? v.mw : 0);
        for (int c = 0; c < total; c++) begin
            rnd = $urandom;
            if (pc !== start_pc) pc_moved++;
            if (reg_we === 1'b1) begin
                reg_we_cycles++;
                wb_seen = wb_sel;
            end
            if (access_idx >= 1 && inst !== v.instr) bad_inst++;
            if (mem_valid === 1'b1) begin
                valid_cycles++;
                if (access_idx == 0) begin
                    if (mem_addr !== start_pc || mem_we !== 1'b0) bad_fetch++;
                    if (inst !== tb_prev_inst) bad_inst++;
                end else if (mem_addr !== v.alu || mem_we !== (v.mem_op == 2)) begin
                    bad_data++;
                end
                target = (access_idx == 0) ? v.fw : v.mw;
                if (wait_cnt >= target) begin
                    mem_ready = 1'b1;
                    mem_rdata = (access_idx == 0) ? v.instr : rnd;
                    access_idx++;
                    wait_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = rnd;
                    wait_cnt++;
                end
            end else begin
                mem_ready = rnd[0];
                mem_rdata = rnd;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        exp_valid = 1 + v.fw + ((v.mem_op != 0) ? 1 + v.mw : 0);
        checkOutput("pc_stable", pc_moved, 0);
        checkOutput("mem_valid_cycles", valid_cycles, exp_valid);
        checkOutput("fetch_request", bad_fetch, 0);
        checkOutput("data_request", bad_data, 0);
        checkOutput("inst_hold", bad_inst, 0);
        checkOutput("reg_we_cycles", reg_we_cycles, v.exp_reg_we ? 1 : 0);
        if (v.exp_reg_we) checkOutput("wb_sel", {30'd0, wb_seen}, {30'd0, v.exp_wb_sel});
        checkOutput("next_pc", pc, v.exp_pc);
        checkOutput("inst_latched", inst, v.instr);
        checkOutput("halted", {31'd0, halted}, {31'd0, v.exp_halt});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, v.exp_illegal});
        checkOutput("end_mem_valid", {31'd0, mem_valid}, {31'd0, !v.exp_halt});
        if (!v.exp_halt) checkOutput("next_fetch_addr", mem_addr, v.exp_pc);
        tb_pc = v.exp_pc;
        tb_prev_inst = v.instr;
    endtask

    task automatic holdHalted(input int n);
        int bad;
        logic [31:0] rnd;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            rnd = $urandom;
            if (mem_valid !== 1'b0 || reg_we !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b1 || pc !== tb_pc) bad++;
            mem_ready = rnd[0];
            @(negedge clk);
        end
        mem_ready = 1'b0;
        checkOutput("halt_hold", bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        v;
        logic [6:0]  legal_ops[10];
        logic [6:0]  op;
        logic [31:0] r1, r2, r3, instr_v, imm_v, alu_v;
        int          sel;

        reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
        imm = 32'h0; alu_result = 32'h0; branch_taken = 1'b0;
        tb_pc = RESET_PC; tb_prev_inst = 32'h0000_0013;

        // rb, instr, imm, alu, taken, fw, mw, exp_pc, reg_we, wb_sel, halt, illegal, cycles, mem_op
        vecs.push_back(mk_vec(1, 32'h00500093, 32'h5,        32'h5,    0, 0, 0, 32'h104,      1, 0, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00500093, 32'h5,        32'h109,  0, 3, 0, 32'h108,      1, 0, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hF8,       32'h0,    0, 0, 0, 32'h200,      1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000A083, 32'h0,        32'h1000, 0, 0, 2, 32'h204,      1, 1, 0, 0, 5, 1));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hFFFFFFFC, 32'h0,    0, 1, 0, 32'h200,      1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0010A023, 32'h0,        32'h1000, 0, 0, 1, 32'h204,      0, 0, 0, 0, 4, 2));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hFFFFFE3C, 32'h0,    0, 0, 0, 32'h40,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00000063, 32'hFFFFFFF8, 32'h0,    1, 0, 0, 32'h38,       0, 0, 0, 0, 3, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'h8,        32'h0,    0, 0, 0, 32'h40,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00000063, 32'hFFFFFFF8, 32'h0,    0, 0, 0, 32'h44,       0, 0, 0, 0, 3, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hFFFFFFFC, 32'h0,    0, 0, 0, 32'h40,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hFFFFFFF8, 32'h0,    0, 0, 0, 32'h38,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'h8,        32'h0,    0, 0, 0, 32'h40,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00008067, 32'h0,        32'h81,   0, 0, 0, 32'h80,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h123450B7, 32'h12345000, 32'h0,    0, 0, 0, 32'h84,       1, 3, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000000F, 32'h0,        32'h0,    0, 0, 0, 32'h88,       0, 0, 0, 0, 3, 0));
        vecs.push_back(mk_vec(0, 32'h00001097, 32'h1000,     32'h1088, 0, 0, 0, 32'h8C,       1, 0, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h002080B3, 32'h0,        32'h7,    0, 0, 0, 32'h90,       1, 0, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'hFFFFFFB0, 32'h0,    0, 0, 0, 32'h40,       1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h0000006F, 32'h2,        32'h0,    0, 0, 0, 32'h40,       0, 0, 1, 1, 4, 0));
        vecs.push_back(mk_vec(1, 32'hFFFFFFFF, 32'h0,        32'h0,    0, 1, 0, 32'h100,      0, 0, 1, 1, 2, 0));
        vecs.push_back(mk_vec(1, 32'h00000073, 32'h0,        32'h0,    0, 0, 0, 32'h100,      0, 0, 1, 0, 2, 0));
        vecs.push_back(mk_vec(1, 32'h0000006F, 32'hFFFFFEFC, 32'h0,    0, 0, 0, 32'hFFFFFFFC, 1, 2, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00500093, 32'h5,        32'h5,    0, 0, 0, 32'h0,        1, 0, 0, 0, 4, 0));
        vecs.push_back(mk_vec(0, 32'h00000063, 32'h6,        32'h0,    1, 0, 0, 32'h0,        0, 0, 1, 1, 3, 0));
        vecs.push_back(mk_vec(1, 32'h00008067, 32'h0,        32'h102,  0, 0, 0, 32'h100,      0, 0, 1, 1, 4, 0));
        vecs.push_back(mk_vec(1, 32'h00000063, 32'h6,        32'h0,    0, 0, 0, 32'h104,      0, 0, 0, 0, 3, 0));
        vecs.push_back(mk_vec(0, 32'h0000A083, 32'h0,        32'h2000, 0, 2, 0, 32'h108,      1, 1, 0, 0, 5, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].reset_before) doReset();
            applyStimulus(vecs[i]);
            if (vecs[i].exp_halt) holdHalted(6);
        end

        // Reset asserted mid-fetch abandons the request and clears state without waiting for a clock.
        doReset();
        applyStimulus(ref_model(32'h00500093, 32'h5, 32'h5, 1'b0, tb_pc));
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_pc", pc, RESET_PC);
        checkOutput("async_reset_inst", inst, 32'h0000_0013);
        @(negedge clk);
        reset = 1'b0;
        tb_pc = RESET_PC;
        tb_prev_inst = 32'h0000_0013;
        checkOutput("restart_mem_valid", {31'd0, mem_valid}, 32'd1);
        checkOutput("restart_mem_addr", mem_addr, RESET_PC);
        applyStimulus(ref_model(32'h00500093, 32'h5, 32'h5, 1'b0, tb_pc));

        legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
        doReset();
        for (int n = 0; n < 300; n++) begin
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            sel = $urandom_range(0, 99);
            if (sel < 3) op = r1[6:0];
            else if (sel < 5) op = 7'b1110011;
            else op = legal_ops[$urandom_range(0, 9)];
            instr_v = {r1[31:7], op};
            imm_v = ($urandom_range(0, 9) == 0) ? r2 : {r2[31:2], 2'b00};
            alu_v = ($urandom_range(0, 9) == 0) ? r3 : {r3[31:2], 1'b0, r3[0]};
            v = ref_model(instr_v, imm_v, alu_v, r3[5], tb_pc);
            v.fw = $urandom_range(0, 2);
            v.mw = $urandom_range(0, 2);
            applyStimulus(v);
            if (v.exp_halt) begin
                holdHalted(3);
                doReset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
